// File: rtl/dff_input_conditioner_pkg.sv
// Shared definitions for the dff input conditioner: FSM state encoding and
// default parameter values reused by the conditioner and its bench.
package dff_input_conditioner_pkg;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } cond_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/dff_input_conditioner_sync_chain.sv
// N-flop synchronizer bringing an asynchronous level into the clk domain.
// Synchronous active-high reset clears every stage to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;

  // shift the raw level in at stage 0, oldest sample falls out at the top
  always_comb begin
    s_d = {s_q[STAGES-2:0], d};
  end

  // synchronizer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/dff_input_conditioner.sv
// Conditions a raw asynchronous level into a clean debounced d for the
// downstream dff: synchronize, debounce with a 4-state FSM, register outputs.
// Optional feature: DFF_COND_EDGE_PULSE_EN compiles registered one-cycle
// rise_p/fall_p pulses; without it both ports are tied 0.
//
// state    | meaning
// S_LOW    | output low, synchronized input agrees
// S_CHK_HI | output low, counting consecutive high samples
// S_HIGH   | output high, synchronized input agrees
// S_CHK_LO | output high, counting consecutive low samples
module dff_input_conditioner
  import dff_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out,
  output logic nq_out,
  output logic rise_p,
  output logic fall_p
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic        ds;
  cond_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        q_q, q_d;
  logic        nq_q, nq_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (d_in),
    .q  (ds)
  );

  // debounce FSM: commit a level only after STABLE_CYCLES equal samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      S_LOW: begin
        cnt_d = '0;
        if (ds) begin
          if (STABLE_CYCLES == 1) begin
            state_d = S_HIGH;
            q_d     = 1'b1;
          end else begin
            state_d = S_CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_CHK_HI: begin
        if (!ds) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          q_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        cnt_d = '0;
        if (!ds) begin
          if (STABLE_CYCLES == 1) begin
            state_d = S_LOW;
            q_d     = 1'b0;
          end else begin
            state_d = S_CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_CHK_LO: begin
        if (ds) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          q_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
    // nq is its own flop loaded from the same next value, so it can never
    // disagree with q for even one cycle
    nq_d = ~q_d;
  end

  // FSM, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      nq_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      nq_q    <= nq_d;
    end
  end

  assign q_out  = q_q;
  assign nq_out = nq_q;

`ifdef DFF_COND_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // a commit is exactly a change between the current and next output level
  always_comb begin
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  // pulses registered alongside q so they coincide with the new level
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_p = rise_q;
  assign fall_p = fall_q;
`else
  assign rise_p = 1'b0;
  assign fall_p = 1'b0;
`endif

endmodule

// File: tb/tb_dff_input_conditioner.sv
// Bench for dff_input_conditioner: default instance plus a SYNC_STAGES=3,
// STABLE_CYCLES=1 instance, both compared every cycle against a reference
// that treats q as "follows the synchronized input once it has held the
// same value for STABLE_CYCLES consecutive samples".
module tb_dff_input_conditioner;

  localparam int SYNC_A = 2;
  localparam int STAB_A = 4;
  localparam int SYNC_B = 3;
  localparam int STAB_B = 1;

`ifdef DFF_COND_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic d_in;
  logic q_a, nq_a, rise_a, fall_a;
  logic q_b, nq_b, rise_b, fall_b;

  always #10 clk = ~clk;

  dff_input_conditioner #(
    .SYNC_STAGES  (SYNC_A),
    .STABLE_CYCLES(STAB_A)
  ) dut_a (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .q_out (q_a),
    .nq_out(nq_a),
    .rise_p(rise_a),
    .fall_p(fall_a)
  );

  dff_input_conditioner #(
    .SYNC_STAGES  (SYNC_B),
    .STABLE_CYCLES(STAB_B)
  ) dut_b (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .q_out (q_b),
    .nq_out(nq_b),
    .rise_p(rise_b),
    .fall_p(fall_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit d_log[$];
  int edge_n   = 0;
  int last_rst = -100;
  int m_sync[2];
  int m_stab[2];
  bit m_q[2];
  bit m_rv[2];
  int m_run[2];
  bit m_rise[2];
  bit m_fall[2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0b expected=%0b edge=%0d", tag, obs, exp, edge_n);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
  endtask

  // synchronized level seen by the debouncer at edge n: d_in from
  // `sync` edges earlier, or 0 while the chain is still flushing a reset
  function automatic bit ds_at(int n, int sync);
    if (n - sync > last_rst) return d_log[n - sync];
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit ds;
    bit nq;
    d_log.push_back(d_in);
    if (rst) last_rst = edge_n;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_q[i]    = 1'b0;
        m_rv[i]   = 1'b0;
        m_run[i]  = 0;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
      end else begin
        ds = ds_at(edge_n, m_sync[i]);
        if (m_run[i] > 0 && ds == m_rv[i]) begin
          if (m_run[i] < 1000) m_run[i]++;
        end else begin
          m_rv[i]  = ds;
          m_run[i] = 1;
        end
        nq = (m_run[i] >= m_stab[i]) ? m_rv[i] : m_q[i];
        m_rise[i] = nq & ~m_q[i];
        m_fall[i] = ~nq & m_q[i];
        m_q[i]    = nq;
      end
    end
    edge_n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("q_a",    q_a,    m_q[0]);
    chk("nq_a",   nq_a,   ~m_q[0]);
    chk("rise_a", rise_a, PULSE_EN & m_rise[0]);
    chk("fall_a", fall_a, PULSE_EN & m_fall[0]);
    chk("q_b",    q_b,    m_q[1]);
    chk("nq_b",   nq_b,   ~m_q[1]);
    chk("rise_b", rise_b, PULSE_EN & m_rise[1]);
    chk("fall_b", fall_b, PULSE_EN & m_fall[1]);
  endtask

  task automatic hold(input bit v, input int n);
    rst  = 1'b0;
    d_in = v;
    for (int i = 0; i < n; i++) step();
  endtask

  // edges (first one counted as 1) until each q reaches tgt; 0 = never
  task automatic measure(input string tag, input bit tgt, input int exp_a, input int exp_b);
    int lat_a;
    int lat_b;
    lat_a = 0;
    lat_b = 0;
    rst  = 1'b0;
    d_in = tgt;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (lat_a == 0 && q_a === tgt) lat_a = i;
      if (lat_b == 0 && q_b === tgt) lat_b = i;
    end
    chk_int({tag, "_lat_a"}, lat_a, exp_a);
    if (exp_b != 0) chk_int({tag, "_lat_b"}, lat_b, exp_b);
  endtask

  initial begin
    int len;
    bit v;
    m_sync[0] = SYNC_A; m_stab[0] = STAB_A;
    m_sync[1] = SYNC_B; m_stab[1] = STAB_B;

    // reset held with d_in high, then full latency after release
    rst  = 1'b1;
    d_in = 1'b1;
    step();
    step();
    measure("reset_rel", 1'b1, 6, 4);
    hold(1'b1, 3);

    // clean fall, clean rise, clean fall
    measure("fall1", 1'b0, 6, 4);
    hold(1'b0, 4);
    measure("rise", 1'b1, 6, 4);
    hold(1'b1, 4);
    measure("fall2", 1'b0, 6, 4);
    hold(1'b0, 6);

    // short glitch must not reach dut_a's output
    hold(1'b1, 3);
    d_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("glitch_q_a", q_a, 1'b0);
    end

    // bounce then settle high: latency counted from last 0->1
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 1);
    measure("bounce", 1'b1, 6, 0);
    hold(1'b1, 4);
    measure("fall3", 1'b0, 6, 4);
    hold(1'b0, 6);

    // reset mid-count (cnt=2 in S_CHK_HI) restarts the whole latency
    hold(1'b1, 4);
    rst = 1'b1;
    step();
    chk("midrst_q_a", q_a, 1'b0);
    measure("midrst", 1'b1, 6, 4);
    hold(1'b1, 4);

    // randomized bursts with occasional reset
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst  = 1'b1;
        d_in = 1'($urandom_range(0, 1));
        step();
      end
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      hold(v, len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
